// File: rtl/mem_sram_ctrl_pkg.sv
// Shared types and defaults for the MEM-stage SRAM controller.
package mem_pkg;

  localparam int SRAM_DW               = 16;
  localparam int DEF_BASE_ADDR         = 1024;
  localparam int DEF_ACCESS_CYCLES     = 3;

  // Access sequencer states; a 32-bit access is two 16-bit half-accesses.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    WR_LO = 3'd3,
    WR_HI = 3'd4,
    DONE  = 3'd5
  } mem_state_e;

endpackage

// File: rtl/sram_phase_counter.sv
// Cycle counter for one SRAM half-access phase; last flags the final cycle.
module sram_phase_counter #(
  parameter int ACCESS_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       enable,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] count,
  output logic       last
);

  // Clear has priority so every phase starts from zero regardless of enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 4'd0;
    end else if (clear) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (enable) begin
      count <= count + 4'd1;
    end
  end

  assign last = (count == 4'(ACCESS_CYCLES - 1));

endmodule

// File: rtl/mem_sram_ctrl.sv
// MEM-stage data-memory controller for a 16-bit external SRAM.
// Handshake: the pipeline presents MEM_R_EN/MEM_W_EN with the address and
// store data and holds them while ready is low (freeze = ~ready); the access
// is accepted in IDLE and completes in the cycle where ready returns high
// (DONE). Enables are only looked at in IDLE, so they may drop mid-access.
module mem_sram_ctrl
  import mem_pkg::*;
#(
  parameter int BASE_ADDR     = DEF_BASE_ADDR,
  parameter int ACCESS_CYCLES = DEF_ACCESS_CYCLES,  // legal range 2..15
  parameter int SRAM_AW       = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_R_EN,
  input  logic               MEM_W_EN,
  input  logic [31:0]        ALU_result,
  input  logic [31:0]        ST_val,
  output logic               ready,
  output logic [31:0]        read_data,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic [SRAM_DW-1:0] SRAM_DQ_out,
  output logic               SRAM_DQ_oe,
  input  logic [SRAM_DW-1:0] SRAM_DQ_in,
  output mem_state_e         state_dbg
);

  mem_state_e         state_q, state_d;
  logic [SRAM_AW-2:0] idx_q;
  logic [31:0]        st_q;
  logic [31:0]        rd_q;
  logic [31:0]        byte_off;
  logic [SRAM_AW-2:0] idx_calc;
  logic               unused_off_bits;
  logic               req;
  logic               cnt_clear;
  logic               cnt_en;
  logic               cnt_last;
  logic [3:0]         cnt;

  assign req      = MEM_R_EN | MEM_W_EN;
  // Word index relative to BASE_ADDR; high bits wrap, byte offset is dropped.
  assign byte_off = ALU_result - 32'(BASE_ADDR);
  assign idx_calc = byte_off[SRAM_AW:2];
  assign unused_off_bits = ^{byte_off[31:SRAM_AW+1], byte_off[1:0], cnt};

  sram_phase_counter #(
    .ACCESS_CYCLES(ACCESS_CYCLES)
  ) u_phase_cnt (
    .clk     (clk),
    .rst_n   (rst),
    .clear   (cnt_clear),
    .enable  (cnt_en),
    .load    (1'b0),
    .load_val(4'd0),
    .count   (cnt),
    .last    (cnt_last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the word index and store data when a request is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q <= '0;
      st_q  <= 32'd0;
    end else if (state_q == IDLE && req) begin
      idx_q <= idx_calc;
      st_q  <= ST_val;
    end
  end

  // Sample each read half on the last cycle of its phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q <= 32'd0;
    end else if (state_q == RD_LO && cnt_last) begin
      rd_q[15:0] <= SRAM_DQ_in;
    end else if (state_q == RD_HI && cnt_last) begin
      rd_q[31:16] <= SRAM_DQ_in;
    end
  end

  // Next-state, phase counter control and ready.
  always_comb begin
    state_d   = state_q;
    cnt_clear = 1'b0;
    cnt_en    = 1'b0;
    ready     = 1'b0;
    case (state_q)
      IDLE: begin
        ready     = ~req;
        cnt_clear = 1'b1;
        if (MEM_R_EN)      state_d = RD_LO;
        else if (MEM_W_EN) state_d = WR_LO;
      end
      RD_LO, WR_LO, RD_HI, WR_HI: begin
        if (cnt_last) begin
          cnt_clear = 1'b1;
          case (state_q)
            RD_LO:   state_d = RD_HI;
            WR_LO:   state_d = WR_HI;
            default: state_d = DONE;
          endcase
        end else begin
          cnt_en = 1'b1;
        end
      end
      DONE: begin
        ready     = 1'b1;
        cnt_clear = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d   = IDLE;
        cnt_clear = 1'b1;
      end
    endcase
  end

  // SRAM pins decode from registered state only; WE_N rises on the last
  // cycle of a write phase so the address never moves under an active strobe.
  always_comb begin
    SRAM_ADDR   = '0;
    SRAM_WE_N   = 1'b1;
    SRAM_DQ_oe  = 1'b0;
    SRAM_DQ_out = '0;
    case (state_q)
      RD_LO: SRAM_ADDR = {idx_q, 1'b0};
      RD_HI: SRAM_ADDR = {idx_q, 1'b1};
      WR_LO: begin
        SRAM_ADDR   = {idx_q, 1'b0};
        SRAM_DQ_oe  = 1'b1;
        SRAM_DQ_out = st_q[15:0];
        SRAM_WE_N   = cnt_last;
      end
      WR_HI: begin
        SRAM_ADDR   = {idx_q, 1'b1};
        SRAM_DQ_oe  = 1'b1;
        SRAM_DQ_out = st_q[31:16];
        SRAM_WE_N   = cnt_last;
      end
      default: ;
    endcase
  end

  assign read_data = rd_q;
  assign state_dbg = state_q;

endmodule
